// File: rtl/fanout_pkg.sv
// Shared types and constants for the eager-fork fanout buffer.
// No ports; imported by the fanout RTL files.
package fanout_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } fanout_state_t;

    localparam int MAX_FANOUT  = 32;
    localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/fanout_fork_buf_if.sv
// Handshake bundle between the upstream source, config and the fork buffer.
// Modports: master (source/consumers side), slave (the buffer itself).
interface fanout_fork_buf_if #(
    parameter int NUM_OUT    = 7,
    parameter int DATA_WIDTH = 17
);
    logic [NUM_OUT-1:0]    cfg_en;
    logic [NUM_OUT-1:0]    cfg_sel;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [NUM_OUT-1:0]    out_valid;
    logic [NUM_OUT-1:0]    out_ready;
    logic                  busy;

    modport master (
        output cfg_en, cfg_sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, busy
    );

    modport slave (
        input  cfg_en, cfg_sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, busy
    );
endinterface

// File: rtl/fanout_ready_reduce.sv
// Combinational fanout-ready reducer: remaining pending mask and done flag.
// Ports: pend_q, out_ready in; pend_next, all_done out.
module fanout_ready_reduce #(
    parameter int NUM_OUT = 7
) (
    input  logic [NUM_OUT-1:0] pend_q,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [NUM_OUT-1:0] pend_next,
    output logic               all_done
);
    assign pend_next = pend_q & ~out_ready;
    assign all_done  = ~|pend_next;
endmodule

// File: rtl/fanout_fork_buf.sv
// One-entry eager-fork buffer: broadcasts a token to all active destinations.
// Ports: CLK, RESET (sync, active-high), bus (slave modport), and
// stall_cnt when FANOUT_STALL_CNT_EN is defined.
module fanout_fork_buf
    import fanout_pkg::*;
#(
    parameter int NUM_OUT    = 7,
    parameter int DATA_WIDTH = 17
) (
    input  logic                   CLK,
    input  logic                   RESET,
`ifdef FANOUT_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
    fanout_fork_buf_if.slave       bus
);
    fanout_state_t         state;
    logic [NUM_OUT-1:0]    pend_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [NUM_OUT-1:0]    pend_next;
    logic                  all_done;
    logic [NUM_OUT-1:0]    act;
    logic                  acc;

    fanout_ready_reduce #(
        .NUM_OUT (NUM_OUT)
    ) u_reduce (
        .pend_q    (pend_q),
        .out_ready (bus.out_ready),
        .pend_next (pend_next),
        .all_done  (all_done)
    );

    assign act = bus.cfg_en & bus.cfg_sel;

    // Ready as soon as this edge retires every pending destination.
    assign bus.in_ready = (state == EMPTY) | all_done;
    assign acc = bus.in_valid & bus.in_ready;

    assign bus.out_valid = pend_q;
    assign bus.out_data  = data_q;
    assign bus.busy      = (state == FULL);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= EMPTY;
            pend_q <= '0;
            data_q <= '0;
        end else if (acc) begin
            // An all-inactive token is consumed and dropped.
            data_q <= bus.in_data;
            pend_q <= act;
            state  <= (act != '0) ? FULL : EMPTY;
        end else if (state == FULL) begin
            pend_q <= pend_next;
            if (all_done)
                state <= EMPTY;
        end
    end

`ifdef FANOUT_STALL_CNT_EN
    always_ff @(posedge CLK) begin
        if (RESET)
            stall_cnt <= '0;
        else if ((state == FULL) && !all_done && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_fanout_fork_buf.sv
// Directed self-checking bench for fanout_fork_buf.
// Covers reset, partial accept, throughput, drop, config change, stall count.
module tb_fanout_fork_buf;
    localparam int N = 7;
    localparam int W = 17;

    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   failures = 0;
    int   hs [N];
    int   snap [N];

`ifdef FANOUT_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    fanout_fork_buf_if #(.NUM_OUT(N), .DATA_WIDTH(W)) bus ();

    fanout_fork_buf #(
        .NUM_OUT    (N),
        .DATA_WIDTH (W)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
`ifdef FANOUT_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .bus       (bus)
    );

    always #5 CLK = ~CLK;

    initial for (int i = 0; i < N; i++) hs[i] = 0;

    // Count every downstream handshake per destination.
    always @(posedge CLK) begin
        if (!RESET)
            for (int i = 0; i < N; i++)
                if (bus.out_valid[i] && bus.out_ready[i])
                    hs[i] = hs[i] + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic take_snap();
        for (int i = 0; i < N; i++) snap[i] = hs[i];
    endtask

    task automatic check_hs(input string tag, input logic [N-1:0] exp1);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_hs%0d", tag, i),
                  64'(hs[i] - snap[i]), exp1[i] ? 64'd1 : 64'd0);
    endtask

    initial begin
        RESET = 1'b1;
        bus.cfg_en = '0;
        bus.cfg_sel = '0;
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = '0;
        tick();
        tick();
        RESET = 1'b0;
        settle();
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_data", 64'(bus.out_data), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ready", 64'(bus.in_ready), 64'd1);

        // 1. reset while FULL
        take_snap();
        bus.cfg_en = 7'h7F;
        bus.cfg_sel = 7'h03;
        bus.in_data = 17'h1ABC;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 7'h01;
        settle();
        check("t1_valid", 64'(bus.out_valid), 64'h03);
        check("t1_busy", 64'(bus.busy), 64'd1);
        check("t1_ready", 64'(bus.in_ready), 64'd0);
        tick();
        check("t1_part", 64'(bus.out_valid), 64'h02);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        bus.out_ready = '0;
        settle();
        check("t1_rvalid", 64'(bus.out_valid), 64'd0);
        check("t1_rbusy", 64'(bus.busy), 64'd0);
        check("t1_rready", 64'(bus.in_ready), 64'd1);
        check_hs("t1", 7'h01);

        // 2. partial accept
        take_snap();
        bus.cfg_sel = 7'h55;
        bus.in_data = 17'h00FF;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 7'h05;
        settle();
        check("t2_v1", 64'(bus.out_valid), 64'h55);
        check("t2_d1", 64'(bus.out_data), 64'h00FF);
        check("t2_r1", 64'(bus.in_ready), 64'd0);
        tick();
        bus.out_ready = 7'h50;
        settle();
        check("t2_v2", 64'(bus.out_valid), 64'h50);
        check("t2_r2", 64'(bus.in_ready), 64'd1);
        tick();
        bus.out_ready = '0;
        settle();
        check("t2_v3", 64'(bus.out_valid), 64'd0);
        check("t2_b3", 64'(bus.busy), 64'd0);
        check_hs("t2", 7'h55);

        // 3. full throughput
        bus.cfg_sel = 7'h7F;
        bus.out_ready = 7'h7F;
        for (int k = 0; k < 8; k++) begin
            bus.in_data = W'(k);
            bus.in_valid = 1'b1;
            settle();
            check($sformatf("t3_rdy%0d", k), 64'(bus.in_ready), 64'd1);
            if (k > 0) begin
                check($sformatf("t3_v%0d", k), 64'(bus.out_valid), 64'h7F);
                check($sformatf("t3_d%0d", k), 64'(bus.out_data), 64'(k - 1));
            end
            tick();
        end
        bus.in_valid = 1'b0;
        settle();
        check("t3_v8", 64'(bus.out_valid), 64'h7F);
        check("t3_d8", 64'(bus.out_data), 64'd7);
        tick();
        check("t3_end", 64'(bus.out_valid), 64'd0);

        // 4. all-unselected drop
        bus.cfg_sel = '0;
        bus.in_data = 17'h0042;
        bus.in_valid = 1'b1;
        settle();
        check("t4_rdy", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        settle();
        check("t4_valid", 64'(bus.out_valid), 64'd0);
        check("t4_busy", 64'(bus.busy), 64'd0);
        check("t4_data", 64'(bus.out_data), 64'h42);

        // 5. config change while FULL
        take_snap();
        bus.out_ready = '0;
        bus.cfg_sel = 7'h01;
        bus.in_data = 17'd1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.cfg_sel = 7'h02;
        settle();
        check("t5_v1", 64'(bus.out_valid), 64'h01);
        tick();
        check("t5_v1b", 64'(bus.out_valid), 64'h01);
        bus.out_ready = 7'h7F;
        bus.in_data = 17'd2;
        bus.in_valid = 1'b1;
        settle();
        check("t5_rdy", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        settle();
        check("t5_v2", 64'(bus.out_valid), 64'h02);
        check("t5_d2", 64'(bus.out_data), 64'd2);
        tick();
        check("t5_busy", 64'(bus.busy), 64'd0);
        check_hs("t5", 7'h03);

`ifdef FANOUT_STALL_CNT_EN
        // 6. stall counter
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        settle();
        check("t6_clr", 64'(stall_cnt), 64'd0);
        bus.out_ready = '0;
        bus.cfg_sel = 7'h01;
        bus.in_valid = 1'b1;
        bus.in_data = 17'd9;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("t6_cnt5", 64'(stall_cnt), 64'd5);
        bus.out_ready = 7'h7F;
        tick();
        check("t6_hold", 64'(stall_cnt), 64'd5);
        check("t6_busy", 64'(bus.busy), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fanout_fork_buf.md
Name: fanout_fork_buf

Overview:
- Parametrised one-entry eager-fork buffer for the sparse-stream fabric.
- Broadcasts one upstream token to up to NUM_OUT downstream consumers.
- A destination is active only when its enable and select bits are both set.
- Tracks per-destination acceptance; the upstream token is consumed only when every active destination has taken it. Successor to the combinational fanout-ready reducers: adds buffering, partial-accept tracking and full throughput.

Parameters:
- NUM_OUT, 7: number of downstream destinations, 1..32.
- DATA_WIDTH, 17: token width (16-bit payload plus control bit).

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset; synchronous, active-high.
- cfg_en  in  NUM_OUT  per-destination enable.
- cfg_sel  in  NUM_OUT  per-destination select; the bit is pre-extracted from the config word by the wrapper.
- in_data  in  DATA_WIDTH  upstream token.
- in_valid  in  1  upstream valid.
- in_ready  out  1  upstream ready.
- out_data  out  DATA_WIDTH  broadcast token, registered.
- out_valid  out  NUM_OUT  per-destination valid, registered.
- out_ready  in  NUM_OUT  per-destination ready.
- busy  out  1  buffer holds an undelivered token.

Behaviour:
- Reset, with RESET high at a CLK edge:
  - state=EMPTY, pend_q=0, data_q=0.
  - Outputs: out_valid=0, out_data=0, busy=0, in_ready=1.
  - Reset mid-operation discards the held token and any partial deliveries.
- Active mask: act = cfg_en & cfg_sel, sampled only at the accept edge.
  - Config changes while FULL affect the next token only.
- States:
  - EMPTY: pend_q=0.
  - FULL: pend_q!=0.
- Outputs from registers:
  - out_valid = pend_q.
  - out_data = data_q.
  - busy = (state==FULL).
- Per-edge delivery: del = pend_q & out_ready; pend_next = pend_q & ~out_ready.
- in_ready = (state==EMPTY) | (pend_next==0).
  - This is a combinational path from out_ready to in_ready, intended for full throughput.
  - in_ready never depends on in_valid.
- Accept (in_valid & in_ready at the edge):
  - data_q <= in_data.
  - pend_q <= act.
  - If act==0, the token is consumed and dropped and the block stays EMPTY (matches the legacy "all unselected -> ready" behaviour).
- FULL without accept: pend_q <= pend_next.
  - When pend_next==0 and there is no new accept, go to EMPTY.
  - data_q holds its value; it is not cleared.
- Simultaneous retire and accept in the same edge:
  - The new token loads, with pend_q <= act.
  - Back-to-back tokens sustain one per cycle when all active destinations are ready.
- Partial accept: a destination that has taken the token sees out_valid[i]=0 until the next token.
  - Its out_ready is then ignored.
  - No destination receives a token twice.
- out_ready[i] is ignored when pend_q[i]=0.
- Latency: one cycle from in accept to out_valid.
- Destinations with out_ready held high drain in the first FULL cycle.

Optional Feature:
- Macro: FANOUT_STALL_CNT_EN.
- With the macro defined:
  - Adds output stall_cnt, 32 bits.
  - It increments on every cycle where state==FULL and pend_next!=0 (some active destination is not ready).
  - It saturates at 0xFFFFFFFF and is cleared by RESET.
- Without the macro: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package fanout_pkg holds:
  - The fanout_state_t enum {EMPTY, FULL}.
  - The localparam MAX_FANOUT=32.
  - The stall-counter width constant STALL_CNT_W=32.
- Sub-module fanout_ready_reduce (combinational, NUM_OUT-parametrised):
  - Computes pend_next and all_done = ~|pend_next from pend_q and out_ready.
  - It is reused by the existing fanout wrappers.

Test Plan:
1. Reset mid-FULL: load token 0x1ABC with act=0b0000011, destination 1 stalled, assert RESET one cycle -> out_valid=0, busy=0, in_ready=1 next cycle; destination 1 never receives 0x1ABC.
2. Partial accept: act=0b1010101, token 0x00FF, out_ready=0b0000101 then 0b1010000 -> first cycle out_valid=0b1010101 and in_ready=0; second cycle out_valid=0b1010000 and in_ready=1; third cycle EMPTY; each destination sees exactly one handshake.
3. Full throughput: act=0b1111111, all out_ready=1, 8 tokens 0..7 on consecutive cycles -> in_ready stays 1, each out_valid bit high 8 consecutive cycles, out_data sequence 0..7.
4. All-unselected drop: cfg_en=0b1111111, cfg_sel=0, token 0x0042 -> accepted in 1 cycle, out_valid stays 0, busy stays 0.
5. Config change while FULL: accept with act=0b0000001 and stall it, change cfg_sel to 0b0000010, then release -> token 1 goes only to destination 0; token 2 goes only to destination 1.
6. FANOUT_STALL_CNT_EN: hold one active destination not-ready for 5 cycles after load -> stall_cnt=5; without the macro the build has no stall_cnt port.
